nv_nvdla_mcif_rd_responder: RTL

- Memory-side responder for the PDP RDMA read interface.
- Accepts read requests of 47-bit payload (32-bit byte address, 15-bit atom count) and returns 65-bit responses (64-bit data plus a 1-bit mask), one 8-byte atom per beat, in request order.
- Outstanding response atoms are bounded by a credit counter that the requester replenishes with a latency-FIFO pop pulse.
- Backed by an internal synchronous RAM that the host or bench preloads. Used as the MCIF stand-in for block-level bring-up and FPGA.

---
 rtl/nv_nvdla_mcif_rd_pkg.sv | 23 ++
 rtl/nv_nvdla_mcif_rd_ram.sv | 29 ++
 rtl/nv_nvdla_mcif_rd_responder.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/nv_nvdla_mcif_rd_pkg.sv
// Shared definitions for the PDP RDMA memory-side read responder:
// payload field offsets, payload widths and the burst FSM state type.
package nv_nvdla_mcif_rd_pkg;

  localparam int REQ_PD_W     = 47;
  localparam int RSP_PD_W     = 65;
  localparam int DATA_W       = 64;
  localparam int SIZE_W       = 15;

  localparam int REQ_ADDR_LSB = 0;
  localparam int REQ_ADDR_MSB = 31;
  localparam int REQ_SIZE_LSB = 32;
  localparam int REQ_SIZE_MSB = 46;

  localparam int RSP_DATA_MSB = 63;
  localparam int RSP_MASK_BIT = 64;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } rd_state_e;

endpackage

// File: rtl/nv_nvdla_mcif_rd_ram.sv
// 1R1W synchronous 64-bit RAM, 2^ADDR_W words. A read that collides with a
// write to the same word in the same cycle returns the old contents.
// Contents are not reset; the host preloads them through the write port.
module nv_nvdla_mcif_rd_ram
  import nv_nvdla_mcif_rd_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] rd_data_q;

  // Write and registered read share one edge, so a colliding read sees old data.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data_q <= mem[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/nv_nvdla_mcif_rd_responder.sv
// Memory-side responder for the PDP RDMA read interface.
// Requests land in a small FIFO; a two-state burst engine turns each into
// one RAM read per 8-byte atom, gated by response credits and by room in a
// 2-entry skid buffer that drives the response port.
// Optional: define MCIF_RD_RSP_RANGE_CHK_EN to flag requests outside the RAM
// (data forced to 0, sticky range_err, saturating range_err_cnt).
//
// Handshakes: a transfer happens on a rising clock edge where valid and ready
// are both high; valid never waits on ready and the payload is held stable
// while valid is high and ready is low.
module nv_nvdla_mcif_rd_responder
  import nv_nvdla_mcif_rd_pkg::*;
#(
  parameter int ADDR_W    = 12,
  parameter int REQ_DEPTH = 4,
  parameter int CDT_DEPTH = 8
) (
  input  logic                nvdla_core_clk,
  input  logic                nvdla_core_rst,
  input  logic                pdp2mcif_rd_req_valid,
  output logic                pdp2mcif_rd_req_ready,
  input  logic [REQ_PD_W-1:0] pdp2mcif_rd_req_pd,
  output logic                mcif2pdp_rd_rsp_valid,
  input  logic                mcif2pdp_rd_rsp_ready,
  output logic [RSP_PD_W-1:0] mcif2pdp_rd_rsp_pd,
  input  logic                pdp2mcif_rd_cdt_lat_fifo_pop,
  input  logic                mem_wr_en,
  input  logic [ADDR_W-1:0]   mem_wr_addr,
  input  logic [DATA_W-1:0]   mem_wr_data,
  output logic                idle
`ifdef MCIF_RD_RSP_RANGE_CHK_EN
  ,
  output logic                range_err,
  output logic [15:0]         range_err_cnt
`endif
);

  localparam int FA_W  = $clog2(REQ_DEPTH);
  localparam int PTR_W = FA_W + 1;
  localparam int CDT_W = $clog2(CDT_DEPTH + 1);
  localparam logic [CDT_W-1:0] CDT_MAX = CDT_W'(CDT_DEPTH);

  // ---------------- request FIFO ----------------
  logic [REQ_PD_W-1:0] fifo_mem [REQ_DEPTH];
  logic [PTR_W-1:0]    fifo_wr_ptr_q, fifo_wr_ptr_d;
  logic [PTR_W-1:0]    fifo_rd_ptr_q, fifo_rd_ptr_d;
  logic                fifo_empty, fifo_full, fifo_push, fifo_pop;
  logic                out_of_reset_q;
  logic [REQ_PD_W-1:0] head_pd;
  logic [31:0]         head_addr;
  logic [SIZE_W-1:0]   head_size;
  logic [ADDR_W-1:0]   head_word;
  logic                unused_addr_bits;

  assign fifo_empty = (fifo_wr_ptr_q == fifo_rd_ptr_q);
  assign fifo_full  = (fifo_wr_ptr_q[FA_W] != fifo_rd_ptr_q[FA_W]) &&
                      (fifo_wr_ptr_q[FA_W-1:0] == fifo_rd_ptr_q[FA_W-1:0]);
  // Ready stays low through reset and rises on the first edge after it.
  assign pdp2mcif_rd_req_ready = out_of_reset_q & ~fifo_full;
  assign fifo_push  = pdp2mcif_rd_req_valid & pdp2mcif_rd_req_ready;
  assign head_pd    = fifo_mem[fifo_rd_ptr_q[FA_W-1:0]];
  assign head_addr  = head_pd[REQ_ADDR_MSB:REQ_ADDR_LSB];
  assign head_size  = head_pd[REQ_SIZE_MSB:REQ_SIZE_LSB];
  // Byte offset within the atom is ignored; the word pointer is the atom index.
  assign head_word  = head_addr[ADDR_W+2:3];

  // Next-state of the FIFO pointers.
  always_comb begin
    fifo_wr_ptr_d = fifo_wr_ptr_q + PTR_W'(fifo_push);
    fifo_rd_ptr_d = fifo_rd_ptr_q + PTR_W'(fifo_pop);
  end

  // FIFO storage; payload is stored exactly as received.
  always_ff @(posedge nvdla_core_clk) begin
    if (fifo_push) fifo_mem[fifo_wr_ptr_q[FA_W-1:0]] <= pdp2mcif_rd_req_pd;
  end

  // FIFO pointers and the post-reset ready enable.
  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      fifo_wr_ptr_q  <= '0;
      fifo_rd_ptr_q  <= '0;
      out_of_reset_q <= 1'b0;
    end else begin
      fifo_wr_ptr_q  <= fifo_wr_ptr_d;
      fifo_rd_ptr_q  <= fifo_rd_ptr_d;
      out_of_reset_q <= 1'b1;
    end
  end

  // ---------------- burst engine ----------------
  rd_state_e         state_q, state_d;
  logic [ADDR_W-1:0] word_ptr_q, word_ptr_d;
  logic [SIZE_W-1:0] remain_q, remain_d;
  logic [CDT_W-1:0]  credit_q, credit_d;
  logic              rd_vld_q;
  logic              issue, rsp_pop, cdt_inc;
  logic [2:0]        occ_after;
  logic [1:0]        skid_cnt_q, skid_cnt_d;

  // Skid slots committed once this cycle's response leaves: the in-flight
  // read will land next edge, so an issue is only safe if one slot remains.
  assign occ_after = 3'(skid_cnt_q) + 3'(rd_vld_q) - 3'(rsp_pop);
  assign issue     = (state_q == BURST) && (credit_q != '0) && (occ_after < 3'd2);

  // Burst FSM next state: IDLE loads the FIFO head, BURST walks the words.
  always_comb begin
    state_d    = state_q;
    word_ptr_d = word_ptr_q;
    remain_d   = remain_q;
    fifo_pop   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          word_ptr_d = head_word;
          remain_d   = head_size;
          state_d    = BURST;
        end
      end
      BURST: begin
        if (issue) begin
          word_ptr_d = word_ptr_q + ADDR_W'(1);
          remain_d   = remain_q - SIZE_W'(1);
          if (remain_q == '0) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Burst FSM registers.
  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      state_q    <= IDLE;
      word_ptr_q <= '0;
      remain_q   <= '0;
    end else begin
      state_q    <= state_d;
      word_ptr_q <= word_ptr_d;
      remain_q   <= remain_d;
    end
  end

  // Credit next state: an issue and a pop together cancel; a lone pop at the
  // full count is dropped so the counter saturates.
  always_comb begin
    cdt_inc  = pdp2mcif_rd_cdt_lat_fifo_pop && (issue || (credit_q != CDT_MAX));
    credit_d = credit_q + CDT_W'(cdt_inc) - CDT_W'(issue);
  end

  // Credit counter and the in-flight read marker.
  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      credit_q <= CDT_MAX;
      rd_vld_q <= 1'b0;
    end else begin
      credit_q <= credit_d;
      rd_vld_q <= issue;
    end
  end

  // ---------------- RAM ----------------
  logic [DATA_W-1:0] ram_rd_data;

  nv_nvdla_mcif_rd_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk     (nvdla_core_clk),
    .wr_en   (mem_wr_en),
    .wr_addr (mem_wr_addr),
    .wr_data (mem_wr_data),
    .rd_en   (issue),
    .rd_addr (word_ptr_q),
    .rd_data (ram_rd_data)
  );

  // ---------------- optional range check ----------------
  logic [DATA_W-1:0] skid_wdata;

`ifdef MCIF_RD_RSP_RANGE_CHK_EN
  localparam int END_W = ADDR_W + SIZE_W + 1;
  logic             oor_q, oor_d, rd_zero_q, head_oor;
  logic [END_W-1:0] head_end;
  logic             range_err_q, range_err_d;
  logic [15:0]      range_err_cnt_q, range_err_cnt_d;

  // Last word of the burst; any carry past ADDR_W bits means it runs off the top.
  assign head_end = END_W'(head_word) + END_W'(head_size);
  assign head_oor = (head_addr[31:ADDR_W+3] != '0) || (head_end[END_W-1:ADDR_W] != '0);
  assign unused_addr_bits = ^head_addr[2:0];
  assign skid_wdata = rd_zero_q ? '0 : ram_rd_data;
  assign range_err     = range_err_q;
  assign range_err_cnt = range_err_cnt_q;

  // Flag is latched with the request and counted once per flagged request.
  always_comb begin
    oor_d           = fifo_pop ? head_oor : oor_q;
    range_err_d     = range_err_q | (fifo_pop & head_oor);
    range_err_cnt_d = range_err_cnt_q;
    if (fifo_pop && head_oor && (range_err_cnt_q != 16'hFFFF))
      range_err_cnt_d = range_err_cnt_q + 16'd1;
  end

  // Range-check state; the zero marker travels with the in-flight read.
  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      oor_q           <= 1'b0;
      rd_zero_q       <= 1'b0;
      range_err_q     <= 1'b0;
      range_err_cnt_q <= '0;
    end else begin
      oor_q           <= oor_d;
      rd_zero_q       <= oor_q;
      range_err_q     <= range_err_d;
      range_err_cnt_q <= range_err_cnt_d;
    end
  end
`else
  assign unused_addr_bits = ^{head_addr[31:ADDR_W+3], head_addr[2:0]};
  assign skid_wdata = ram_rd_data;
`endif

  // ---------------- response skid buffer ----------------
  logic [DATA_W-1:0] skid_mem [2];
  logic              skid_wr_ptr_q, skid_wr_ptr_d;
  logic              skid_rd_ptr_q, skid_rd_ptr_d;

  assign mcif2pdp_rd_rsp_valid = (skid_cnt_q != 2'd0);
  assign rsp_pop = mcif2pdp_rd_rsp_valid & mcif2pdp_rd_rsp_ready;

  // Response payload: head entry with mask set, zero when nothing is held.
  always_comb begin
    mcif2pdp_rd_rsp_pd = '0;
    if (mcif2pdp_rd_rsp_valid) begin
      mcif2pdp_rd_rsp_pd[RSP_DATA_MSB:0] = skid_mem[skid_rd_ptr_q];
      mcif2pdp_rd_rsp_pd[RSP_MASK_BIT]   = 1'b1;
    end
  end

  // Skid pointer and occupancy next state.
  always_comb begin
    skid_wr_ptr_d = skid_wr_ptr_q ^ rd_vld_q;
    skid_rd_ptr_d = skid_rd_ptr_q ^ rsp_pop;
    skid_cnt_d    = skid_cnt_q + 2'(rd_vld_q) - 2'(rsp_pop);
  end

  // Skid storage, written by every returning RAM read.
  always_ff @(posedge nvdla_core_clk) begin
    if (rd_vld_q) skid_mem[skid_wr_ptr_q] <= skid_wdata;
  end

  // Skid pointers and occupancy.
  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      skid_wr_ptr_q <= 1'b0;
      skid_rd_ptr_q <= 1'b0;
      skid_cnt_q    <= 2'd0;
    end else begin
      skid_wr_ptr_q <= skid_wr_ptr_d;
      skid_rd_ptr_q <= skid_rd_ptr_d;
      skid_cnt_q    <= skid_cnt_d;
    end
  end

  assign idle = fifo_empty && (state_q == IDLE) && (skid_cnt_q == 2'd0) && !rd_vld_q;

endmodule
